// File: rtl/md_pkg.sv
// Op codes and FSM states shared by the multicycle multiply/divide unit
// and anything that decodes MULT/DIV/MTHI/MTLO instructions for it.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle, sign handled as magnitudes plus flags.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             isDiv_q, isDiv_d;
  logic             negRes_q, negRes_d;
  logic             negRem_q, negRem_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Two's-complement negate when neg is set; used for operand abs and result fix-up.
  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic             signedOp, arg1Neg, arg2Neg;
  logic [WIDTH-1:0] arg1Mag, arg2Mag;
  logic [WIDTH-1:0] accHi, accLo;
  logic [WIDTH-1:0] mulAddend;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] divDiff, divRem;
  logic             divTake;
  logic [DW-1:0]    accMul, accDiv;
  logic [WIDTH-1:0] resLo, resHiMul, resHiDiv;

  assign signedOp = (op == MD_MULT) || (op == MD_DIV);
  assign arg1Neg  = signedOp & arg1[WIDTH-1];
  assign arg2Neg  = signedOp & arg2[WIDTH-1];
  assign arg1Mag  = applySign(arg1, arg1Neg);
  assign arg2Mag  = applySign(arg2, arg2Neg);

  assign accHi = acc_q[DW-1:WIDTH];
  assign accLo = acc_q[WIDTH-1:0];

  assign mulAddend = accLo[0] ? opb_q : '0;
  assign mulSum    = {1'b0, accHi} + {1'b0, mulAddend};
  assign accMul    = {mulSum, accLo[WIDTH-1:1]};

  // The trial remainder is below 2*divisor, so a WIDTH-bit difference is exact.
  assign divTrial = {accHi, accLo[WIDTH-1]};
  assign divTake  = divTrial >= {1'b0, opb_q};
  assign divDiff  = divTrial[WIDTH-1:0] - opb_q;
  assign divRem   = divTake ? divDiff : divTrial[WIDTH-1:0];
  assign accDiv   = {divRem, accLo[WIDTH-2:0], divTake};

  // Negating {H,L}: low half negates alone, high half borrows only when L is nonzero.
  assign resLo    = applySign(accLo, negRes_q);
  assign resHiMul = applySign(accHi, negRes_q) - WIDTH'(negRes_q && (accLo != '0));
  assign resHiDiv = applySign(accHi, negRem_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              isDiv_d   = op[1];
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? arg1Mag : arg2Mag)};
              opb_d     = op[1] ? arg2Mag : arg1Mag;
              negRes_d  = arg1Neg ^ arg2Neg;
              negRem_d  = arg1Neg;
              divZero_d = (arg2 == '0);
              cnt_d     = CNT_W'(WIDTH);
              state_d   = S_CALC;
            end
            MD_MTHI: begin
              hi_d   = arg1;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = arg1;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = isDiv_q ? accDiv : accMul;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Division by zero keeps the natural remainder (the dividend) but forces quotient to all ones.
        hi_d    = isDiv_q ? resHiDiv : resHiMul;
        lo_d    = (isDiv_q && divZero_q) ? '1 : resLo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide unit with HI/LO result registers, sitting beside the single-cycle ALU in the EX stage of the five-stage pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in one cycle.
- Exposes `busy` so hazard control stalls dependent MFHI/MFLO and further mult/div ops.
- Generalises the ALU in operand width and adds the sequential behaviour the ALU lacks.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal range 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when state is IDLE
- op  in  3  operation code, sampled with start
- arg1  in  WIDTH  RS value: multiplicand, dividend, or MTHI/MTLO source
- arg2  in  WIDTH  RT value: multiplier or divisor
- busy  out  1  high while an iterative op is in flight
- done  out  1  one-cycle pulse; HI/LO hold the new values in this cycle
- hi  out  WIDTH  HI register: product upper half or remainder
- lo  out  WIDTH  LO register: product lower half or quotient

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
- rst in any state aborts the op; no done pulse; HI/LO are zeroed.
- Op codes:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 110/111 reserved: no state change, no done.
- States: IDLE, CALC, FIX.
- IDLE with start=1 and op MULT..DIVU:
  - Latch operand magnitudes: the absolute value for signed ops, raw value for unsigned ops.
  - Latch result-sign flags and op.
  - Set counter=WIDTH, go to CALC, busy=1 from the next cycle.
- CALC: one step per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Decrement counter; when counter reaches 1, go to FIX after this step.
  - CALC lasts exactly WIDTH cycles.
- FIX (1 cycle): apply sign correction, write HI/LO, assert done for the next cycle, clear busy, go to IDLE.
- Latency:
  - start sampled at edge 0; busy high for WIDTH+1 cycles.
  - done is high in cycle WIDTH+2 together with the new HI/LO.
  - start in the done cycle is accepted; back-to-back ops are allowed.
- MTHI/MTLO in IDLE:
  - hi (or lo) is loaded with arg1 at that edge; the other register is unchanged.
  - done pulses the following cycle; busy never asserts.
- start while busy: ignored entirely; no queuing, no error.
- Signed multiply: product negated when the operand signs differ; full 2*WIDTH result, no overflow.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1: lo=most-negative, hi=0 (wrap, no trap).
- Divide by zero, signed or unsigned: lo=all ones, hi=arg1 unmodified. The op still takes the full latency.
- arg1/arg2/op are don't-care except in the start-accept cycle.
- hi/lo are stable outside the completing edge.

Decomposition:
- Shared package md_pkg:
  - op-code localparams MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - state encodings S_IDLE, S_CALC, S_FIX.
- No sub-module is needed. Sign-magnitude conversion is a local function, since the same abs/negate logic serves load and FIX.

Test Plan (WIDTH=32):
- MULT, arg1=0xFFFFFFFD (-3), arg2=7:
  - busy high 33 cycles; done in cycle 34.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU, 0xFFFFFFFF*2 → hi=0x00000001, lo=0xFFFFFFFE. Then DIVU 100/7 with start in the done cycle → lo=14, hi=2, with no idle gap.
- DIV:
  - -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234 after full latency. A second start with op=MULT at cycle 5 is ignored: result unchanged, a single done pulse.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A:
  - each gives a done pulse with busy=0.
  - hi/lo hold the written values; reserved op 110 yields no done and no change.
- MULT 5*5 with rst asserted at CALC cycle 10:
  - next cycle busy=0, hi=lo=0, state IDLE.
  - no done pulse.
  - a subsequent MULT 5*5 gives lo=25.
